// File: rtl/sl3_link_monitor.sv
// SL3 per-port link monitor: lane-lock FSM, neighbour beacon tracking,
// saturating ECC error counters and link health.
module sl3_link_monitor #(
  parameter int NUM_PORTS      = 4,
  parameter int NUM_LANES      = 2,
  parameter int CNT_WIDTH      = 32,
  parameter int LOCK_DEBOUNCE  = 16,
  parameter int BEACON_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS*NUM_LANES-1:0] word_lock,
  input  logic [NUM_PORTS-1:0]           hard_error,
  input  logic [NUM_PORTS-1:0]           sbe_pulse,
  input  logic [NUM_PORTS-1:0]           dbe_pulse,
  input  logic [NUM_PORTS-1:0]           oob_valid,
  input  logic [NUM_PORTS*15-1:0]        oob_data,
  input  logic                           clear_ecc_err_cnt,
  input  logic [NUM_PORTS-1:0]           link_reset,
  output logic [NUM_PORTS*8-1:0]         neighbor_node_id,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] single_bit_ecc_err_cnt,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] double_bit_ecc_err_cnt,
  output logic [NUM_PORTS*2-1:0]         link_state,
  output logic [NUM_PORTS-1:0]           present,
  output logic [NUM_PORTS-1:0]           healthy,
  output logic [NUM_PORTS-1:0]           link_up_event
);

  typedef enum logic [1:0] {
    DOWN    = 2'd0,
    LOCKING = 2'd1,
    UP      = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam int DW =
    (LOCK_DEBOUNCE > 1) ? $clog2(LOCK_DEBOUNCE) : 1;
  localparam int TW = $clog2(BEACON_TIMEOUT + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(LOCK_DEBOUNCE - 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(BEACON_TIMEOUT);
  localparam logic [2:0]    ID_TYPE = 3'b001;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [NUM_LANES-1:0] lanes;
    logic                 all_lock;
    logic                 any_lock;
    logic                 beacon;
    logic                 unused_oob;
    state_t               state;
    state_t               state_nx;
    logic [DW-1:0]        dcnt;
    logic [DW-1:0]        dcnt_nx;
    logic                 up_evt;
    logic [TW-1:0]        tmo;
    logic [7:0]           nid;
    logic [CNT_WIDTH-1:0] sbe_cnt;
    logic [CNT_WIDTH-1:0] dbe_cnt;

    assign lanes    = word_lock[p*NUM_LANES +: NUM_LANES];
    assign all_lock = &lanes;
    assign any_lock = |lanes;
    assign beacon   = oob_valid[p] &&
                      (oob_data[p*15+12 +: 3] == ID_TYPE);
    assign unused_oob = ^oob_data[p*15+8 +: 4];

    always_comb begin
      state_nx = state;
      dcnt_nx  = dcnt;
      unique case (state)
        DOWN: begin
          if (all_lock && !hard_error[p]) begin
            state_nx = LOCKING;
            dcnt_nx  = '0;
          end
        end
        LOCKING: begin
          if (!all_lock || hard_error[p]) begin
            state_nx = DOWN;
          end else if (dcnt == DB_LAST) begin
            state_nx = UP;
          end else begin
            dcnt_nx = dcnt + 1'b1;
          end
        end
        UP: begin
          if (!all_lock || hard_error[p]) begin
            state_nx = FAULT;
          end
        end
        FAULT: begin
          if (!any_lock && !hard_error[p]) begin
            state_nx = DOWN;
          end
        end
      endcase
      if (link_reset[p]) begin
        state_nx = DOWN;
        dcnt_nx  = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= DOWN;
        dcnt   <= '0;
        up_evt <= 1'b0;
      end else begin
        state  <= state_nx;
        dcnt   <= dcnt_nx;
        up_evt <= (state_nx == UP) && (state != UP);
      end
    end

    // link_reset drops presence but keeps the last known neighbour ID
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tmo <= '0;
        nid <= 8'hFF;
      end else begin
        if (beacon) begin
          nid <= oob_data[p*15 +: 8];
        end
        if (link_reset[p]) begin
          tmo <= '0;
        end else if (beacon) begin
          tmo <= TO_LOAD;
        end else if (tmo != '0) begin
          tmo <= tmo - 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sbe_cnt <= '0;
        dbe_cnt <= '0;
      end else if (clear_ecc_err_cnt) begin
        sbe_cnt <= '0;
        dbe_cnt <= '0;
      end else begin
        if (sbe_pulse[p] && !(&sbe_cnt)) begin
          sbe_cnt <= sbe_cnt + 1'b1;
        end
        if (dbe_pulse[p] && !(&dbe_cnt)) begin
          dbe_cnt <= dbe_cnt + 1'b1;
        end
      end
    end

    assign link_state[p*2 +: 2]          = state;
    assign present[p]                    = |tmo;
    assign healthy[p]                    = (state == UP) && (|tmo)
                                           && !up_evt;
    assign link_up_event[p]              = up_evt;
    assign neighbor_node_id[p*8 +: 8]    = nid;
    assign single_bit_ecc_err_cnt[p*CNT_WIDTH +: CNT_WIDTH] = sbe_cnt;
    assign double_bit_ecc_err_cnt[p*CNT_WIDTH +: CNT_WIDTH] = dbe_cnt;
  end

endmodule

// File: tb/tb_sl3_link_monitor.sv
// Bench for sl3_link_monitor: directed link scenarios, a vector table
// for the fault path, and random traffic against a behavioural model.
module tb_sl3_link_monitor;

  localparam int NP = 4;
  localparam int NL = 2;
  localparam int CW = 4;
  localparam int LD = 16;
  localparam int BT = 8;

  localparam int S_DOWN = 0;
  localparam int S_LOCK = 1;
  localparam int S_UP   = 2;
  localparam int S_FLT  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP*NL-1:0] word_lock;
  logic [NP-1:0]    hard_error;
  logic [NP-1:0]    sbe_pulse;
  logic [NP-1:0]    dbe_pulse;
  logic [NP-1:0]    oob_valid;
  logic [NP*15-1:0] oob_data;
  logic             clear_ecc_err_cnt;
  logic [NP-1:0]    link_reset;
  logic [NP*8-1:0]  neighbor_node_id;
  logic [NP*CW-1:0] single_bit_ecc_err_cnt;
  logic [NP*CW-1:0] double_bit_ecc_err_cnt;
  logic [NP*2-1:0]  link_state;
  logic [NP-1:0]    present;
  logic [NP-1:0]    healthy;
  logic [NP-1:0]    link_up_event;

  sl3_link_monitor #(
    .NUM_PORTS(NP), .NUM_LANES(NL), .CNT_WIDTH(CW),
    .LOCK_DEBOUNCE(LD), .BEACON_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .word_lock(word_lock), .hard_error(hard_error),
    .sbe_pulse(sbe_pulse), .dbe_pulse(dbe_pulse),
    .oob_valid(oob_valid), .oob_data(oob_data),
    .clear_ecc_err_cnt(clear_ecc_err_cnt),
    .link_reset(link_reset),
    .neighbor_node_id(neighbor_node_id),
    .single_bit_ecc_err_cnt(single_bit_ecc_err_cnt),
    .double_bit_ecc_err_cnt(double_bit_ecc_err_cnt),
    .link_state(link_state), .present(present),
    .healthy(healthy), .link_up_event(link_up_event)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // behavioural model: cycles spent locking, beacon age, plain counts
  int m_st[NP];
  int m_run[NP];
  int m_tmo[NP];
  int m_nid[NP];
  int m_sbe[NP];
  int m_dbe[NP];
  bit m_evt[NP];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_st[p] = S_DOWN; m_run[p] = 0; m_tmo[p] = 0;
      m_nid[p] = 8'hFF; m_sbe[p] = 0; m_dbe[p] = 0; m_evt[p] = 0;
    end
  endtask

  task automatic model_step();
    for (int p = 0; p < NP; p++) begin
      logic [1:0]  ln;
      logic [14:0] w;
      bit all, none, he;
      int prev, ns;
      ln   = word_lock[p*NL +: NL];
      w    = oob_data[p*15 +: 15];
      all  = (ln == 2'b11);
      none = (ln == 2'b00);
      he   = hard_error[p];
      prev = m_st[p];
      ns   = prev;
      if (link_reset[p]) begin
        ns = S_DOWN;
      end else if (prev == S_DOWN) begin
        if (all && !he) begin ns = S_LOCK; m_run[p] = 1; end
      end else if (prev == S_LOCK) begin
        if (!all || he) ns = S_DOWN;
        else if (m_run[p] == LD) ns = S_UP;
        else m_run[p]++;
      end else if (prev == S_UP) begin
        if (!all || he) ns = S_FLT;
      end else begin
        if (none && !he) ns = S_DOWN;
      end
      m_st[p]  = ns;
      m_evt[p] = (ns == S_UP) && (prev != S_UP);
      if (oob_valid[p] && w[14:12] == 3'b001) m_nid[p] = int'(w[7:0]);
      if (link_reset[p]) m_tmo[p] = 0;
      else if (oob_valid[p] && w[14:12] == 3'b001) m_tmo[p] = BT;
      else if (m_tmo[p] > 0) m_tmo[p]--;
      if (clear_ecc_err_cnt) begin
        m_sbe[p] = 0; m_dbe[p] = 0;
      end else begin
        if (sbe_pulse[p]) m_sbe[p] = (m_sbe[p] + 1 > 15) ? 15 : m_sbe[p] + 1;
        if (dbe_pulse[p]) m_dbe[p] = (m_dbe[p] + 1 > 15) ? 15 : m_dbe[p] + 1;
      end
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NP; p++) begin
      bit hl;
      hl = (m_st[p] == S_UP) && (m_tmo[p] != 0) && !m_evt[p];
      chk($sformatf("state[%0d]", p), link_state[p*2 +: 2], m_st[p]);
      chk($sformatf("present[%0d]", p), present[p], m_tmo[p] != 0);
      chk($sformatf("healthy[%0d]", p), healthy[p], hl);
      chk($sformatf("up_event[%0d]", p), link_up_event[p], m_evt[p]);
      chk($sformatf("nid[%0d]", p), neighbor_node_id[p*8 +: 8], m_nid[p]);
      chk($sformatf("sbe[%0d]", p), single_bit_ecc_err_cnt[p*CW +: CW], m_sbe[p]);
      chk($sformatf("dbe[%0d]", p), double_bit_ecc_err_cnt[p*CW +: CW], m_dbe[p]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    sbe_pulse = '0; dbe_pulse = '0; oob_valid = '0;
    clear_ecc_err_cnt = 1'b0; link_reset = '0;
  endtask

  task automatic chk_reset_values(string tag);
    chk({tag, " state"}, link_state, 0);
    chk({tag, " present"}, present, 0);
    chk({tag, " healthy"}, healthy, 0);
    chk({tag, " up_event"}, link_up_event, 0);
    chk({tag, " nid"}, neighbor_node_id, 32'hFFFF_FFFF);
    chk({tag, " sbe"}, single_bit_ecc_err_cnt, 0);
    chk({tag, " dbe"}, double_bit_ecc_err_cnt, 0);
  endtask

  typedef struct {
    logic [1:0] wl;
    logic       he;
    logic       lr;
    logic       bcn;
    logic [1:0] st;
    logic       hl;
    logic       pr;
  } vec_t;

  vec_t tbl[8];
  logic [1:0] cur_lock[NP];

  initial begin
    tbl[0] = '{2'b11, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1};
    tbl[1] = '{2'b11, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1};
    tbl[2] = '{2'b11, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1};
    tbl[3] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1};
    tbl[4] = '{2'b00, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1};
    tbl[5] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[6] = '{2'b11, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[7] = '{2'b11, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    word_lock = '0; hard_error = '0; sbe_pulse = '0; dbe_pulse = '0;
    oob_valid = '0; oob_data = '0; clear_ecc_err_cnt = 1'b0;
    link_reset = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    rst_n = 1'b1;

    // lock-up on port 0
    word_lock[1:0] = 2'b11;
    tick();
    chk("lockup locking", link_state[1:0], S_LOCK);
    repeat (15) tick();
    chk("lockup still locking", link_state[1:0], S_LOCK);
    tick();
    chk("lockup up", link_state[1:0], S_UP);
    chk("lockup event", link_up_event[0], 1'b1);
    tick();
    chk("lockup event once", link_up_event[0], 1'b0);

    // non-ID OOB ignored, then ID beacon and timeout
    oob_valid[0] = 1'b1; oob_data[14:0] = 15'h2033;
    tick();
    chk("oob other nid", neighbor_node_id[7:0], 8'hFF);
    chk("oob other present", present[0], 1'b0);
    oob_valid[0] = 1'b1; oob_data[14:0] = 15'h10A5;
    tick();
    chk("beacon nid", neighbor_node_id[7:0], 8'hA5);
    chk("beacon present", present[0], 1'b1);
    chk("beacon healthy", healthy[0], 1'b1);
    repeat (7) tick();
    chk("beacon hold", present[0], 1'b1);
    tick();
    chk("timeout present", present[0], 1'b0);
    chk("timeout healthy", healthy[0], 1'b0);

    // lane drop during LOCKING on port 1
    word_lock[3:2] = 2'b11;
    repeat (11) tick();
    word_lock[3:2] = 2'b01;
    tick();
    chk("drop down", link_state[3:2], S_DOWN);
    chk("drop no event", link_up_event[1], 1'b0);
    word_lock[3:2] = 2'b11;
    repeat (16) tick();
    chk("relock count", link_state[3:2], S_LOCK);
    tick();
    chk("relock up", link_state[3:2], S_UP);

    // fault path table on port 1
    for (int i = 0; i < 8; i++) begin
      word_lock[3:2] = tbl[i].wl;
      hard_error[1]  = tbl[i].he;
      link_reset[1]  = tbl[i].lr;
      oob_valid[1]   = tbl[i].bcn;
      oob_data[29:15] = 15'h10C3;
      tick();
      chk($sformatf("tbl%0d state", i), link_state[3:2], tbl[i].st);
      chk($sformatf("tbl%0d healthy", i), healthy[1], tbl[i].hl);
      chk($sformatf("tbl%0d present", i), present[1], tbl[i].pr);
    end

    // link_reset while UP
    repeat (17) tick();
    chk("relink up", link_state[3:2], S_UP);
    oob_valid[1] = 1'b1;
    tick();
    chk("relink healthy", healthy[1], 1'b1);
    link_reset[1] = 1'b1;
    tick();
    chk("lreset state", link_state[3:2], S_DOWN);
    chk("lreset present", present[1], 1'b0);
    chk("lreset nid kept", neighbor_node_id[15:8], 8'hC3);

    // ECC saturation and clear priority
    for (int i = 0; i < 20; i++) begin
      sbe_pulse[2] = 1'b1;
      if (i < 5) dbe_pulse[3] = 1'b1;
      tick();
    end
    chk("sbe saturate", single_bit_ecc_err_cnt[11:8], 4'hF);
    chk("dbe count", double_bit_ecc_err_cnt[15:12], 4'h5);
    clear_ecc_err_cnt = 1'b1; sbe_pulse[2] = 1'b1; dbe_pulse[3] = 1'b1;
    tick();
    chk("clear sbe", single_bit_ecc_err_cnt[11:8], 4'h0);
    chk("clear dbe", double_bit_ecc_err_cnt[15:12], 4'h0);

    // async reset with port 2 mid-LOCKING
    word_lock = 8'b1100_1111; hard_error = '0;
    repeat (20) tick();
    oob_valid = 4'b1011; oob_data = {15'h1011, 15'h1022, 15'h1033, 15'h1044};
    sbe_pulse = 4'b1111;
    tick();
    word_lock[5:4] = 2'b11;
    repeat (5) tick();
    chk("pre-reset p2", link_state[5:4], S_LOCK);
    chk("pre-reset p0", link_state[1:0], S_UP);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_values("async");
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_values("held");
    rst_n = 1'b1;
    tick();
    chk("post-reset lock", link_state[1:0], S_LOCK);

    // random traffic
    for (int p = 0; p < NP; p++) cur_lock[p] = 2'b11;
    hard_error = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(29) == 0)
          cur_lock[p] = ($urandom_range(1) == 1) ? 2'b11 : 2'($urandom_range(3));
        word_lock[p*NL +: NL] = cur_lock[p];
        if (hard_error[p]) hard_error[p] = ($urandom_range(7) != 0);
        else hard_error[p] = ($urandom_range(79) == 0);
        sbe_pulse[p]  = ($urandom_range(3) == 0);
        dbe_pulse[p]  = ($urandom_range(4) == 0);
        oob_valid[p]  = ($urandom_range(5) == 0);
        oob_data[p*15 +: 15] = {(($urandom_range(1) == 1) ? 3'b001
                                 : 3'($urandom_range(7))), 12'($urandom)};
        link_reset[p] = ($urandom_range(149) == 0);
      end
      clear_ecc_err_cnt = ($urandom_range(59) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
